// File: rtl/tft_bus_arbiter_if.sv
// rtl/tft_bus_arbiter_if.sv - requester and tft_spi side signals shared through the TFT bus arbiter
interface tft_bus_arbiter_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_dc;
    logic [NUM_REQ-1:0]   req_transmit;
    logic                 tft_busy;
    logic [7:0]           tft_data;
    logic                 tft_dc;
    logic                 tft_transmit;
    logic [NUM_REQ-1:0]   grant;
    logic [IDW-1:0]       grant_id;
    logic                 bus_idle;
    logic                 timeout_flag;
    logic [IDW-1:0]       timeout_id;

    modport master (
        output req, req_data, req_dc, req_transmit, tft_busy,
        input  tft_data, tft_dc, tft_transmit, grant, grant_id, bus_idle, timeout_flag, timeout_id
    );

    modport slave (
        input  req, req_data, req_dc, req_transmit, tft_busy,
        output tft_data, tft_dc, tft_transmit, grant, grant_id, bus_idle, timeout_flag, timeout_id
    );
endinterface

// File: rtl/tft_bus_arbiter.sv
// rtl/tft_bus_arbiter.sv - non-preemptive arbiter sharing one tft_spi byte transmitter
module tft_bus_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ROUND_ROBIN = 0,
    parameter int TIMEOUT     = 65535,
    parameter int GAP_CYCLES  = 1
) (
    input  logic             clk,
    input  logic             rst,
    tft_bus_arbiter_if.slave bus
);
    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GAP_N = (GAP_CYCLES > 1) ? GAP_CYCLES : 1;
    localparam int GW    = (GAP_N > 1) ? $clog2(GAP_N) : 1;

    localparam logic [TW-1:0]  TMAX     = TW'(TIMEOUT);
    localparam logic [GW-1:0]  GLAST    = GW'(GAP_N - 1);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NUM_REQ - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     last_grant_q, last_grant_d;
    logic [IDW-1:0]     timeout_id_q, timeout_id_d;
    logic               timeout_flag_q, timeout_flag_d;
    logic               bus_idle_q, bus_idle_d;
    logic [TW-1:0]      wd_cnt_q, wd_cnt_d;
    logic [GW-1:0]      gap_cnt_q, gap_cnt_d;

    logic [NUM_REQ-1:0] cand;
    logic               win_found;
    logic [IDW-1:0]     win_id;
    logic               owner_req;
    logic               owner_tx;
    logic               wd_expire;
    int                 idx;

    assign cand      = bus.req & ~mask_q;
    assign owner_req = bus.req[grant_id_q];
    assign owner_tx  = bus.req_transmit[grant_id_q];

    // Rotating search starts just after the previous owner; fixed mode starts at index 0.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (ROUND_ROBIN != 0) ? ((int'(last_grant_q) + 1 + k) % NUM_REQ) : k;
            if (!win_found && cand[IDW'(idx)]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        grant_id_d     = grant_id_q;
        last_grant_d   = last_grant_q;
        timeout_flag_d = timeout_flag_q;
        timeout_id_d   = timeout_id_q;
        mask_d         = mask_q & bus.req;
        wd_cnt_d       = wd_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        wd_expire      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d      = S_GRANT;
                    grant_d      = NUM_REQ'(1) << win_id;
                    grant_id_d   = win_id;
                    last_grant_d = win_id;
                    wd_cnt_d     = '0;
                end
            end
            S_GRANT: begin
                if (owner_tx || bus.tft_busy) begin
                    wd_cnt_d = '0;
                end else if (wd_cnt_q != TMAX) begin
                    wd_cnt_d = wd_cnt_q + TW'(1);
                end
                wd_expire = (TIMEOUT != 0) && (wd_cnt_d == TMAX);
                // A release in the expiry cycle wins over the revoke.
                if (!owner_req) begin
                    state_d = S_DRAIN;
                    grant_d = '0;
                end else if (wd_expire) begin
                    state_d              = S_DRAIN;
                    grant_d              = '0;
                    timeout_flag_d       = 1'b1;
                    timeout_id_d         = grant_id_q;
                    mask_d[grant_id_q]   = 1'b1;
                end
            end
            S_DRAIN: begin
                if (!bus.tft_busy) begin
                    state_d   = S_GAP;
                    gap_cnt_d = '0;
                end
            end
            default: begin
                if (gap_cnt_q == GLAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
        endcase
        bus_idle_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            grant_q        <= '0;
            grant_id_q     <= '0;
            last_grant_q   <= LAST_RST;
            timeout_flag_q <= 1'b0;
            timeout_id_q   <= '0;
            mask_q         <= '0;
            wd_cnt_q       <= '0;
            gap_cnt_q      <= '0;
            bus_idle_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            grant_id_q     <= grant_id_d;
            last_grant_q   <= last_grant_d;
            timeout_flag_q <= timeout_flag_d;
            timeout_id_q   <= timeout_id_d;
            mask_q         <= mask_d;
            wd_cnt_q       <= wd_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            bus_idle_q     <= bus_idle_d;
        end
    end

    always_comb begin
        bus.tft_data     = 8'h00;
        bus.tft_dc       = 1'b0;
        bus.tft_transmit = 1'b0;
        if (state_q == S_GRANT) begin
            bus.tft_data     = bus.req_data[{grant_id_q, 3'b000} +: 8];
            bus.tft_dc       = bus.req_dc[grant_id_q];
            bus.tft_transmit = owner_tx;
        end
    end

    assign bus.grant        = grant_q;
    assign bus.grant_id     = grant_id_q;
    assign bus.bus_idle     = bus_idle_q;
    assign bus.timeout_flag = timeout_flag_q;
    assign bus.timeout_id   = timeout_id_q;
endmodule

// File: doc/tft_bus_arbiter.md
Name: tft_bus_arbiter

Overview:
- Shares the single tft_spi byte transmitter between several drawing requesters: tft_init, scene_exhibitor, player, and future overlays.
- Replaces the combinational enable-priority mux in the top level with a non-preemptive arbiter that owns the sequencing.
- Grants are held for a whole drawing job. The bus is released only at a byte boundary, and a hung requester is revoked by a watchdog.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 is the highest priority.
- ROUND_ROBIN, 0, 0 selects fixed priority (lowest index wins); 1 selects rotating priority starting after the last granted index.
- TIMEOUT, 65535, idle cycles allowed for a granted requester before revocation; 0 disables the watchdog.
- GAP_CYCLES, 1, idle cycles inserted between consecutive grants, minimum 1.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester bus request, held high for the whole job
- req_data  in  8*NUM_REQ  byte from requester i, in slice [8i+7:8i]
- req_dc  in  NUM_REQ  data/command select from requester i
- req_transmit  in  NUM_REQ  transmit strobe from requester i
- tft_busy  in  1  busy output of tft_spi
- tft_data  out  8  byte to tft_spi
- tft_dc  out  1  dc to tft_spi
- tft_transmit  out  1  transmit strobe to tft_spi
- grant  out  NUM_REQ  one-hot grant; all zero when no owner
- grant_id  out  $clog2(NUM_REQ)  index of the current owner; holds the last value when idle
- bus_idle  out  1  high in IDLE with no pending grant
- timeout_flag  out  1  sticky; set on a watchdog revoke, cleared only by rst
- timeout_id  out  $clog2(NUM_REQ)  index of the last revoked requester

Behaviour:

Reset (rst high at a clk edge):
- State goes to IDLE. grant=0, grant_id=0, tft_data=0, tft_dc=0, tft_transmit=0, bus_idle=1, timeout_flag=0, timeout_id=0.
- Revoke mask and watchdog counter clear. rst mid-job abandons the grant immediately.

State IDLE:
- The candidate set is req & ~mask.
- If the set is non-empty, select a winner and go to GRANT next cycle.
  - Fixed priority: the lowest set index wins.
  - Round robin: the first set index searched upward from (last_grant+1) mod NUM_REQ.
- grant is registered and asserts in the cycle after req is seen. Arbitration latency is 1 cycle.

State GRANT:
- tft_data, tft_dc and tft_transmit follow the owner's inputs combinationally.
- All non-owner strobes are ignored.
- When the owner drops req, go to DRAIN.
- If the watchdog expires, go to DRAIN and additionally:
  - set timeout_flag;
  - set timeout_id to the owner;
  - set mask[owner].

State DRAIN:
- grant is already 0 and tft_transmit is forced to 0.
- Stay while tft_busy=1. When tft_busy=0, go to GAP.

State GAP:
- Outputs are forced to 0 for GAP_CYCLES cycles, then return to IDLE.
- req sampled during GAP is honoured in IDLE.

Watchdog:
- Counter of width clog2(TIMEOUT+1), counting only in GRANT.
- Cleared on grant entry, on any owner req_transmit pulse, and on every cycle tft_busy=1.
- Expires when the count reaches TIMEOUT. It is not incremented past TIMEOUT.

Mask:
- mask[i] clears in any cycle where req[i]=0.
- A revoked requester therefore must deassert req before it can win again.

Simultaneous events:
- Owner drops req in the same cycle as watchdog expiry: treated as a normal release; the flag is not set.
- Requests arriving during GRANT, DRAIN or GAP are held pending. No preemption, including by index 0.
- If tft_busy is already high on grant entry, the owner is responsible for waiting; the arbiter does not gate transmit on tft_busy.

Widths:
- grant_id and last_grant wrap mod NUM_REQ.
- All outputs are registered except the data/dc/transmit passthrough in GRANT.

Test Plan:
1. Grant latency and passthrough:
   - Stimulus: after rst, req=4'b0110 simultaneously.
   - Required: grant=4'b0010 one cycle later, grant_id=1.
   - Stimulus: owner 1 sends 0x2A with dc=1.
   - Required: tft_data=0x2A, tft_dc=1, tft_transmit pulses the same cycle.
2. Release and gap:
   - Stimulus: requester 1 drops req while tft_busy=1 for 10 more cycles.
   - Required: grant=0 immediately; tft_transmit=0 through the drain; grant=4'b0100 exactly GAP_CYCLES+1 cycles after tft_busy falls.
3. Non-preemption and round robin:
   - Stimulus: fixed mode, req[0] rises during requester 2's job.
   - Required: no grant change until requester 2 releases; then requester 0 wins.
   - Stimulus: ROUND_ROBIN=1, req=4'b1111 held, each owner releases after 3 bytes.
   - Required: grant order 0,1,2,3,0.
4. Watchdog:
   - Stimulus: TIMEOUT=20, requester 3 granted, no transmit, tft_busy=0.
   - Required: revoke at the 20th idle cycle, timeout_flag=1, timeout_id=3; requester 3 is not regranted while req[3] stays high; requester 3 is regranted after req[3] toggles low then high.
5. Reset mid-job:
   - Stimulus: rst for 1 cycle during an owner byte.
   - Required: next cycle grant=0, tft_transmit=0, timeout_flag=0, bus_idle=1.
6. Flag on release:
   - Stimulus: owner drops req on the exact expiry cycle.
   - Required: timeout_flag stays 0, normal DRAIN.
